// File: rtl/key_scan_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// key_scan_pkg
// Shared definitions for the key scan scheduler:
//   - state_e          : shared-timer state machine encoding
//   - bit_width()      : bits needed to hold a non-negative value (min 1)
//   - debounce_cycles(): debounce window in clock cycles
//   - wrap_add()       : modular add of two in-range indices
// -----------------------------------------------------------------------------
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    // Number of bits required to represent value; 0 and 1 both need one bit.
    function automatic int bit_width(input int value);
        int w;
        w = 1;
        for (int b = 1; b < 31; b++) begin
            w = ((value >> b) != 0) ? b + 1 : w;
        end
        return w;
    endfunction

    function automatic int debounce_cycles(input int window_ns, input int period_ns);
        return window_ns / period_ns;
    endfunction

    // a and b are both below n, so one conditional subtraction wraps the sum.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/key_scan_scheduler_if.sv
// -----------------------------------------------------------------------------
// key_scan_scheduler_if
// Button inputs and debounced outputs of the key scan scheduler.
//   key        : raw asynchronous button levels (high = pressed)
//   key_pulse  : one-cycle pulse per accepted press
//   busy       : shared timer is counting or sampling
//   active_idx : key currently (or last) timed
// master = button/consumer side, slave = scheduler.
// -----------------------------------------------------------------------------
interface key_scan_scheduler_if #(
    parameter int N_KEYS = 4
);
    import key_scan_pkg::*;

    localparam int IDX_W = bit_width(N_KEYS - 1);

    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_pulse;
    logic              busy;
    logic [IDX_W-1:0]  active_idx;

    modport master (
        output key,
        input  key_pulse,
        input  busy,
        input  active_idx
    );

    modport slave (
        input  key,
        output key_pulse,
        output busy,
        output active_idx
    );

endinterface

// File: rtl/key_scan_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder: returns the first set bit of pending_i
// searching upward from rr_ptr_i with wrap-around.
//   pending_i   : request vector
//   rr_ptr_i    : search start index (always < N_KEYS)
//   grant_idx_o : selected index (0 when nothing pending)
//   valid_o     : at least one request pending
// -----------------------------------------------------------------------------
module rr_pick
    import key_scan_pkg::*;
#(
    parameter int N_KEYS = 4,
    parameter int IDX_W  = 2
) (
    input  logic [N_KEYS-1:0] pending_i,
    input  logic [IDX_W-1:0]  rr_ptr_i,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              valid_o
);

    // Scan offsets from farthest to nearest; the nearest hit overwrites the rest.
    always_comb begin
        grant_idx_o = '0;
        for (int k = N_KEYS - 1; k >= 0; k--) begin
            grant_idx_o = pending_i[IDX_W'(wrap_add(int'(rr_ptr_i), k, N_KEYS))]
                        ? IDX_W'(wrap_add(int'(rr_ptr_i), k, N_KEYS))
                        : grant_idx_o;
        end
    end

    assign valid_o = |pending_i;

endmodule

// File: rtl/key_scan_scheduler.sv
// -----------------------------------------------------------------------------
// key_scan_scheduler
// Debounces N_KEYS push-buttons with one shared timer. Rising edges are latched
// as pending requests; a round-robin arbiter hands one request at a time to the
// timer, and the key level is re-checked at the end of the window.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : key_scan_scheduler_if.slave (key in; key_pulse, busy, active_idx out)
// -----------------------------------------------------------------------------
module key_scan_scheduler
    import key_scan_pkg::*;
#(
    parameter int CLK_PERIOD  = 5,
    parameter int N_KEYS      = 4,
    parameter int DEBOUNCE_NS = 20_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    key_scan_scheduler_if.slave  bus
);

    localparam int DEBOUNCE_CYCLES = debounce_cycles(DEBOUNCE_NS, CLK_PERIOD);
    localparam int CNT_W           = bit_width(DEBOUNCE_CYCLES);
    localparam int IDX_W           = bit_width(N_KEYS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_KEYS - 1);

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] key_s_q;
    logic [N_KEYS-1:0] key_dly_q;
    logic [N_KEYS-1:0] pending_q;
    logic [N_KEYS-1:0] pending_d;
    logic [N_KEYS-1:0] rise_s;
    logic [N_KEYS-1:0] set_s;
    logic [N_KEYS-1:0] clr_s;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  active_idx_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [N_KEYS-1:0] pulse_q;
    logic              busy_q;

    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_valid_s;

    rr_pick #(
        .N_KEYS (N_KEYS),
        .IDX_W  (IDX_W)
    ) u_rr_pick (
        .pending_i   (pending_q),
        .rr_ptr_i    (rr_ptr_q),
        .grant_idx_o (grant_idx_s),
        .valid_o     (grant_valid_s)
    );

    // Pending update: new edges set, a grant clears; the clear wins on overlap.
    always_comb begin
        rise_s = key_s_q & ~key_dly_q;
        set_s  = rise_s;
        clr_s  = '0;
        // An edge on the key under timing is contact bounce, not a new press.
        if (state_q != IDLE) begin
            set_s[active_idx_q] = 1'b0;
        end else begin
            set_s = rise_s;
        end
        if ((state_q == IDLE) && grant_valid_s) begin
            clr_s[grant_idx_s] = 1'b1;
        end else begin
            clr_s = '0;
        end
        pending_d = (pending_q | set_s) & ~clr_s;
    end

    // Two-flop synchroniser, edge-detect delay flop and pending request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            key_s_q   <= '0;
            key_dly_q <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= bus.key;
            key_s_q   <= sync1_q;
            key_dly_q <= key_s_q;
            pending_q <= pending_d;
        end
    end

    // Shared-timer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            active_idx_q <= '0;
            rr_ptr_q     <= '0;
            pulse_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            pulse_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant_valid_s) begin
                        active_idx_q <= grant_idx_s;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= COUNT;
                    end else begin
                        state_q      <= IDLE;
                    end
                end
                COUNT: begin
                    // Stop at the last count so the counter never wraps.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (key_s_q[active_idx_q]) begin
                        pulse_q[active_idx_q] <= 1'b1;
                    end else begin
                        pulse_q <= '0;
                    end
                    rr_ptr_q <= (active_idx_q == IDX_LAST) ? '0 : active_idx_q + IDX_W'(1);
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_pulse  = pulse_q;
    assign bus.busy       = busy_q;
    assign bus.active_idx = active_idx_q;

endmodule

// File: doc/key_scan_scheduler.md
Name: key_scan_scheduler

Overview:
- Debounces N_KEYS high-active push-buttons with one shared delay counter instead of one counter per key.
- Each key is synchronised and rising-edge detected, then latched as a pending request.
- A round-robin arbiter grants one pending key at a time to the shared timer. The key level is re-sampled after the debounce window.
- Emits one-cycle pulses per key to the mode/config logic of the PAM4-RGB transmitter.

Parameters:
- CLK_PERIOD, 5, input clock period in ns (200 MHz).
- N_KEYS, 4, number of buttons; legal range 2..16.
- DEBOUNCE_NS, 20_000_000, debounce window in ns.
- DEBOUNCE_CYCLES (local), DEBOUNCE_NS/CLK_PERIOD, must be >= 2; counter width = bit width of DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- key  in  N_KEYS  raw asynchronous button levels, high = pressed.
- key_pulse  out  N_KEYS  one-cycle registered pulse per accepted press; at most one bit set per cycle.
- busy  out  1  high while the shared timer is in COUNT or SAMPLE.
- active_idx  out  bit width of N_KEYS-1  index of the key currently being timed; holds its last value when idle.

Behaviour:
- Reset: synchronous on clk, active-high; clears all sync flops, pending, counter and rr pointer. Forces state IDLE, key_pulse=0, busy=0, active_idx=0. Reset during COUNT/SAMPLE abandons the press; no pulse is emitted.
- Sync: two flops per key (key_s), plus a delayed copy key_d.
- Edge: edge[i] = key_s[i] & ~key_d[i].
- Cycle E is the cycle edge[i] is high.
- Pending: pending[i] is set at E+1 unless i == active_idx while busy. An edge on the key being timed is bounce and is dropped.
- Pending coincides with a grant of the same index: the clear wins.
- State machine:
  - IDLE: if pending != 0, grant the first set bit searching upward from rr_ptr with wrap. Set active_idx, clear that pending bit, counter=0, go COUNT. Otherwise stay.
  - COUNT: counter += 1 each cycle. When counter == DEBOUNCE_CYCLES-1, go SAMPLE.
  - SAMPLE: if key_s[active_idx]==1, register key_pulse[active_idx]=1 for the next cycle only. Set rr_ptr = active_idx+1, wrapping at N_KEYS. Go IDLE.
- Latency: for an uncontended key, key_pulse is high exactly in cycle E+DEBOUNCE_CYCLES+3, for one cycle.
- Contention: each further queued key adds DEBOUNCE_CYCLES+2 cycles (SAMPLE→IDLE→grant). Presses are never lost, only serialised.
- Key released (key_s==0) at SAMPLE: no pulse; the request is consumed.
- Key held indefinitely: one pulse only. A new pulse needs a release then a new rising edge.
- Counter never wraps; it is reset on every grant.

Decomposition:
- Shared package key_scan_pkg holds:
  - state enum {IDLE, COUNT, SAMPLE};
  - the bit-width helper function;
  - the DEBOUNCE_CYCLES derivation.
- One sub-module, rr_pick: combinational round-robin first-set finder.
  - Inputs: pending vector and rr_ptr.
  - Outputs: grant index and a valid flag.
- The sync/edge stage and FSM stay in the top level.

Test Plan (CLK_PERIOD=5, DEBOUNCE_NS=50 → DEBOUNCE_CYCLES=10, N_KEYS=4):
- Single press: key[1] rises cleanly and is held → key_pulse=4'b0010 in exactly one cycle, E+13; busy high E+2..E+12.
- Simultaneous: key[0] and key[2] rise together, both held → pulse[0] at E+13, pulse[2] at E+25; never both in one cycle.
- Bounce: key[3] toggles 5 times within 8 cycles after its first edge, then held high → exactly one pulse[3]; pending[3] never re-set.
- Glitch: key[1] high for 3 cycles, then low → no pulse; busy returns low after SAMPLE.
- Fairness: key[0] re-pressed continuously while key[3] is pending → grants alternate 0,3,0,3; key[3] waits at most one window.
- Reset mid-count: rst asserted at counter=5 on key[2] → no pulse; outputs zero next cycle; a fresh press afterwards gives its pulse at E+13.
